// File: rtl/param_fetch.sv
// param_fetch: fetches a burst of parameter rows from a synchronous memory
// and streams them out through a small row FIFO with valid/ready handshake.
// Issue is throttled so that buffered plus in-flight rows never exceed the
// FIFO depth, which makes overflow impossible without backpressuring memory.
module param_fetch #(
   parameter int unsigned DEP        = 8,
   parameter int unsigned LEN        = 8,
   parameter int unsigned WIDTH      = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [LEN-1:0]                base_addr,
   input  logic [LEN:0]                  count,
   output logic                          mem_en,
   output logic [LEN-1:0]                mem_addr,
   input  logic signed [WIDTH*DEP-1:0]   mem_data,
   output logic signed [WIDTH*DEP-1:0]   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned ROW_W = WIDTH * DEP;
   localparam int unsigned REM_W = LEN + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [REM_W-1:0] remaining;
   logic [REM_W-1:0] rem_nxt;
   logic [LEN-1:0]   next_addr;
   logic [LEN-1:0]   addr_nxt;
   logic             issue_c;
   logic [LEN-1:0]   issue_addr_c;
   logic             issue_last_c;
   logic             en_last;
   logic             cap;
   logic             cap_last;

   logic [FIFO_DEPTH-1:0][ROW_W-1:0] data_q;
   logic [FIFO_DEPTH-1:0][ROW_W-1:0] data_nxt;
   logic [FIFO_DEPTH-1:0]            last_q;
   logic [FIFO_DEPTH-1:0]            last_nxt;
   logic [2:0]                       entries;
   logic [2:0]                       entries_nxt;
   logic [2:0]                       level;
   logic [2:0]                       inflight_c;
   logic                             room_c;
   logic                             pop_c;

   assign out_data = data_q[0];
   assign out_last = last_q[0];

   // Rows issued but not yet written: one in the memory, one in the capture stage
   assign inflight_c = 3'(mem_en) + 3'(cap);
   assign room_c     = (entries + inflight_c) < 3'(FIFO_DEPTH);
   assign pop_c      = out_valid & out_ready;

   // Next-state and issue decision; first row is issued on the start edge
   always_comb begin
      state_nxt    = state;
      issue_c      = 1'b0;
      issue_addr_c = next_addr;
      issue_last_c = 1'b0;
      rem_nxt      = remaining;
      addr_nxt     = next_addr;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  issue_c      = 1'b1;
                  issue_addr_c = base_addr;
                  issue_last_c = (count == REM_W'(1));
                  rem_nxt      = count - REM_W'(1);
                  addr_nxt     = base_addr + LEN'(1);
                  state_nxt    = S_FETCH;
               end else begin
                  rem_nxt   = '0;
                  state_nxt = S_DONE;
               end
            end
         end
         S_FETCH: begin
            if (remaining == '0) begin
               state_nxt = S_DRAIN;
            end else if (room_c) begin
               issue_c      = 1'b1;
               issue_addr_c = next_addr;
               issue_last_c = (remaining == REM_W'(1));
               rem_nxt      = remaining - REM_W'(1);
               addr_nxt     = next_addr + LEN'(1);
               if (remaining == REM_W'(1)) begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop_c && last_q[0]) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Issue pipeline, capture flag and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         next_addr <= '0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         en_last   <= 1'b0;
         cap       <= 1'b0;
         cap_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         remaining <= rem_nxt;
         next_addr <= addr_nxt;
         mem_en    <= issue_c;
         en_last   <= issue_c & issue_last_c;
         if (issue_c) begin
            mem_addr <= issue_addr_c;
         end
         cap       <= mem_en;
         cap_last  <= en_last;
         busy      <= (state_nxt == S_FETCH) || (state_nxt == S_DRAIN);
         done      <= (state_nxt == S_DONE);
      end
   end

   // Shift-register FIFO: entry 0 is the head, pop shifts down, push fills the tail
   always_comb begin
      data_nxt = data_q;
      last_nxt = last_q;
      level    = entries;
      if (pop_c) begin
         for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
            data_nxt[i] = data_q[i+1];
            last_nxt[i] = last_q[i+1];
         end
         data_nxt[FIFO_DEPTH-1] = '0;
         last_nxt[FIFO_DEPTH-1] = 1'b0;
         level = entries - 3'd1;
      end
      if (cap) begin
         data_nxt[level[1:0]] = mem_data;
         last_nxt[level[1:0]] = cap_last;
         level = level + 3'd1;
      end
      entries_nxt = level;
   end

   // FIFO storage and registered valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q    <= '0;
         last_q    <= '0;
         entries   <= '0;
         out_valid <= 1'b0;
      end else begin
         data_q    <= data_nxt;
         last_q    <= last_nxt;
         entries   <= entries_nxt;
         out_valid <= (entries_nxt != 3'd0);
      end
   end

endmodule

// File: tb/tb_param_fetch.sv
// Testbench for param_fetch: memory model, address/row scoreboards and
// directed bursts covering latency, wrap, backpressure, empty, busy-start,
// mid-burst reset and a full-address-space burst with random ready.
module tb_param_fetch;

   localparam int unsigned DEP   = 8;
   localparam int unsigned LEN   = 8;
   localparam int unsigned WIDTH = 2;
   localparam int unsigned ROW_W = WIDTH * DEP;

   typedef struct packed {
      logic [ROW_W-1:0] data;
      logic             last;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [LEN-1:0]    base_addr = '0;
   logic [LEN:0]      count = '0;
   logic              mem_en;
   logic [LEN-1:0]    mem_addr;
   logic [ROW_W-1:0]  mem_data;
   logic [ROW_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [ROW_W-1:0]  mem_q = '0;
   logic              junk = 1'b0;

   exp_t              exp_q[$];
   logic [LEN-1:0]    addr_q[$];
   int                n_checks = 0;
   int                n_fail = 0;
   int                issue_cnt = 0;
   bit                prev_stall = 1'b0;
   logic [ROW_W-1:0]  prev_data = '0;

   param_fetch #(.DEP(DEP), .LEN(LEN), .WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [ROW_W-1:0] row_of(input logic [LEN-1:0] a);
      return {a ^ 8'h5A, a + 8'h33};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory: row valid in the cycle after mem_en, zero otherwise; junk forces garbage
   always @(posedge clk) mem_q <= mem_en ? row_of(mem_addr) : '0;
   assign mem_data = junk ? 16'hBEEF : mem_q;

   // Scoreboard monitor: issued addresses, transferred rows, stall stability
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_en) begin
            issue_cnt++;
            check_eq("addr_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) check_eq("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
         end
         if (out_valid && out_ready) begin
            check_eq("row_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check_eq("out_data", 32'(out_data), 32'(e.data));
               check_eq("out_last", 32'(out_last), 32'(e.last));
            end
         end
         if (prev_stall && out_valid) begin
            check_eq("hold_data", 32'(out_data), 32'(prev_data));
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic set_rdy(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic start_burst(input logic [LEN-1:0] b, input logic [LEN:0] c, input bit expect_it);
      logic [LEN-1:0] a;
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      count = c;
      if (expect_it) begin
         for (int i = 0; i < int'(c); i++) begin
            a = b + 8'(i);
            addr_q.push_back(a);
            e.data = row_of(a);
            e.last = (i == int'(c) - 1);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1 if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      out_ready = out_ready;
      @(negedge clk);
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("busy_after_done", 32'(busy), 32'd0);
      check_eq("rows_left", 32'(exp_q.size()), 32'd0);
      check_eq("addrs_left", 32'(addr_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [ROW_W-1:0] held;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      set_rdy(1'b1);

      // Basic burst with exact cycle timing
      start_burst(8'h10, 9'd3, 1'b1);
      @(negedge clk);
      check_eq("b_en_s", 32'(mem_en), 32'd1);
      check_eq("b_busy_s", 32'(busy), 32'd1);
      check_eq("b_valid_s", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("b_en_s1", 32'(mem_en), 32'd1);
      check_eq("b_valid_s1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("b_en_s2", 32'(mem_en), 32'd1);
      check_eq("b_valid_s2", 32'(out_valid), 32'd1);
      check_eq("b_last_s2", 32'(out_last), 32'd0);
      @(negedge clk);
      check_eq("b_en_s3", 32'(mem_en), 32'd0);
      check_eq("b_valid_s3", 32'(out_valid), 32'd1);
      @(negedge clk);
      check_eq("b_valid_s4", 32'(out_valid), 32'd1);
      check_eq("b_last_s4", 32'(out_last), 32'd1);
      wait_done(20, 1'b0, cyc);
      check_eq("b_done_latency", 32'(cyc), 32'd1);

      // Address wrap-around
      start_burst(8'hFE, 9'd4, 1'b1);
      wait_done(40, 1'b0, cyc);

      // Backpressure: issue throttled to FIFO capacity
      set_rdy(1'b0);
      issue_cnt = 0;
      start_burst(8'h40, 9'd8, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("bp_issue_cnt", 32'(issue_cnt), 32'd4);
      check_eq("bp_mem_en", 32'(mem_en), 32'd0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_head", 32'(out_data), 32'(row_of(8'h40)));
      check_eq("bp_busy", 32'(busy), 32'd1);
      held = out_data;
      set_rdy(1'b1);
      wait_done(60, 1'b0, cyc);
      check_eq("bp_issue_total", 32'(issue_cnt), 32'd8);
      check_eq("bp_held_row", 32'(held), 32'(row_of(8'h40)));

      // Empty burst
      start_burst(8'h00, 9'd0, 1'b1);
      @(negedge clk);
      check_eq("e_done_s", 32'(done), 32'd1);
      check_eq("e_busy_s", 32'(busy), 32'd0);
      check_eq("e_en_s", 32'(mem_en), 32'd0);
      @(negedge clk);
      check_eq("e_done_s1", 32'(done), 32'd0);
      check_eq("e_busy_s1", 32'(busy), 32'd0);
      check_eq("e_en_s1", 32'(mem_en), 32'd0);

      // Start while busy is ignored
      start_burst(8'h80, 9'd5, 1'b1);
      @(negedge clk);
      start_burst(8'h20, 9'd3, 1'b0);
      wait_done(60, 1'b0, cyc);

      // Mid-burst reset with two rows in flight
      start_burst(8'h30, 9'd6, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check_eq("r_inflight_en", 32'(mem_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      exp_q.delete();
      addr_q.delete();
      check_eq("r_mem_en", 32'(mem_en), 32'd0);
      check_eq("r_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("r_busy", 32'(busy), 32'd0);
      check_eq("r_valid", 32'(out_valid), 32'd0);
      check_eq("r_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      junk = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("r_no_capture", 32'(out_valid), 32'd0);
         check_eq("r_no_issue", 32'(mem_en), 32'd0);
      end
      junk = 1'b0;
      start_burst(8'hA0, 9'd2, 1'b1);
      wait_done(40, 1'b0, cyc);

      // Full address space burst with random ready
      issue_cnt = 0;
      start_burst(8'h05, 9'd256, 1'b1);
      wait_done(3000, 1'b1, cyc);
      check_eq("full_issue_cnt", 32'(issue_cnt), 32'd256);
      set_rdy(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
